// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the ID sources and a load's destination in EX.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    output logic                 hazard
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign hazard  = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: drives PC and pipeline-register enables/flushes
// for load-use, taken branches, multi-cycle MUL/DIV and memory busywait.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 ex_muldiv_start,
    input  logic                 muldiv_done,
    input  logic                 imem_busy,
    input  logic                 dmem_busy,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 pc_redirect,
    output logic [CNT_W-1:0]     stall_cycles
);

    hz_state_e        state_q, state_d;
    logic             flush_pending_q, flush_pending_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic run_mode;
    logic md_stall;
    logic any_stall;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .hazard      (load_use)
    );

    // A completing MUL/DIV lets MD_WAIT behave exactly like RUN for that cycle.
    assign run_mode = (state_q == ST_RUN) || muldiv_done;
    assign md_stall = (state_q == ST_MD_WAIT) && !muldiv_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            flush_pending_q <= 1'b0;
            stall_cycles_q  <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        stall_cycles_d  = stall_cycles_q;

        if (!dmem_busy) begin
            if (flush_pending_q && !imem_busy) begin
                flush_pending_d = 1'b0;
            end
            if (md_stall) begin
                state_d = ST_MD_WAIT;
            end else if (run_mode) begin
                state_d = ST_RUN;
                if (ex_branch_taken) begin
                    if (imem_busy) begin
                        flush_pending_d = 1'b1;
                    end
                end else if (ex_muldiv_start && !muldiv_done) begin
                    state_d = ST_MD_WAIT;
                end
            end
        end

        if (any_stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_redirect  = 1'b0;

        if (dmem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else begin
            if (md_stall || (ex_muldiv_start && !muldiv_done && !ex_branch_taken)) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
            end else if (ex_branch_taken) begin
                pc_redirect = 1'b1;
                id_ex_flush = 1'b1;
                if (imem_busy) begin
                    if_id_en = 1'b0;
                end else begin
                    if_id_flush = 1'b1;
                end
            end else if (load_use || imem_busy) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end

            // The wrong-path fetch that was in flight at redirect lands now; squash it.
            if (flush_pending_q && !imem_busy) begin
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    assign any_stall    = !(pc_en && if_id_en && id_ex_en && ex_mem_en && mem_wb_en);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 32;

    // {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_flush,id_ex_flush,ex_mem_flush,pc_redirect}
    localparam logic [8:0] O_RUN    = 9'b11111_000_0;
    localparam logic [8:0] O_STALL  = 9'b00111_010_0;
    localparam logic [8:0] O_BR     = 9'b11111_110_1;
    localparam logic [8:0] O_BR_BSY = 9'b10111_010_1;
    localparam logic [8:0] O_MD     = 9'b00011_001_0;
    localparam logic [8:0] O_FRZ    = 9'b00000_000_0;
    localparam logic [8:0] O_PCLR   = 9'b11111_100_0;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read;
    logic             ex_branch_taken, ex_muldiv_start, muldiv_done;
    logic             imem_busy, dmem_busy;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect;
    logic [CNT_W-1:0] stall_cycles;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_cnt = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .muldiv_done     (muldiv_done),
        .imem_busy       (imem_busy),
        .dmem_busy       (dmem_busy),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .pc_redirect     (pc_redirect),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    logic [8:0] outs;
    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect};

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0; muldiv_done = 1'b0;
        imem_busy = 1'b0; dmem_busy = 1'b0;
    endtask

    // Check outputs mid-cycle, then advance one clock; track the expected counter.
    task automatic cyc(input string tag, input logic [8:0] exp_o);
        @(negedge clk);
        check_vec(tag, 32'(outs), 32'(exp_o));
        if (exp_o[8:4] != 5'b11111) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_vec("reset_cnt", 32'(stall_cycles), 32'd0);
        cyc("reset_outs", O_RUN);

        // load-use on rs1, then x0 destination, then rs2, then rs2 unused
        ex_rd = 5'd5; ex_mem_read = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cyc("lu_rs1", O_STALL);
        check_vec("lu_cnt", 32'(stall_cycles), 32'd1);
        ex_rd = 5'd0; id_rs1 = 5'd0;
        cyc("lu_x0", O_RUN);
        clear_in();
        ex_rd = 5'd7; ex_mem_read = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_rs1 = 5'd7;
        cyc("lu_rs2", O_STALL);
        id_use_rs2 = 1'b0;
        cyc("lu_unused", O_RUN);
        check_vec("lu_cnt2", 32'(stall_cycles), exp_cnt);

        // taken branch, imem idle; branch also beats a load-use
        clear_in();
        ex_branch_taken = 1'b1;
        cyc("br_free", O_BR);
        ex_rd = 5'd3; ex_mem_read = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        cyc("br_over_lu", O_BR);
        clear_in();

        // taken branch under imem busy for 3 cycles
        ex_branch_taken = 1'b1; imem_busy = 1'b1;
        cyc("br_busy", O_BR_BSY);
        ex_branch_taken = 1'b0;
        cyc("pend_busy1", O_STALL);
        cyc("pend_busy2", O_STALL);
        imem_busy = 1'b0;
        cyc("pend_clear", O_PCLR);
        cyc("pend_done", O_RUN);
        check_vec("br_cnt", 32'(stall_cycles), exp_cnt);

        // 33-cycle divide
        ex_muldiv_start = 1'b1;
        for (int i = 0; i < 33; i++) cyc("div_wait", O_MD);
        muldiv_done = 1'b1;
        cyc("div_done", O_RUN);
        check_vec("div_cnt", 32'(stall_cycles), 32'd38);
        ex_muldiv_start = 1'b0; muldiv_done = 1'b0;
        cyc("div_after", O_RUN);
        ex_muldiv_start = 1'b1; muldiv_done = 1'b1;
        cyc("mul_1cyc", O_RUN);
        ex_muldiv_start = 1'b0; muldiv_done = 1'b0;
        cyc("mul_after", O_RUN);
        check_vec("mul_cnt", 32'(stall_cycles), 32'd38);

        // dmem freeze mid MD_WAIT with a load-use present
        ex_muldiv_start = 1'b1;
        cyc("md_enter", O_MD);
        dmem_busy = 1'b1; ex_rd = 5'd9; ex_mem_read = 1'b1; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
        cyc("frz_md1", O_FRZ);
        cyc("frz_md2", O_FRZ);
        dmem_busy = 1'b0; ex_mem_read = 1'b0;
        cyc("md_resume", O_MD);
        muldiv_done = 1'b1;
        cyc("md_resume_done", O_RUN);
        clear_in();
        cyc("md_resume_run", O_RUN);
        check_vec("frz_cnt", 32'(stall_cycles), exp_cnt);

        // dmem freeze drops a branch; pending survives a freeze
        ex_branch_taken = 1'b1; dmem_busy = 1'b1;
        cyc("frz_br", O_FRZ);
        clear_in();
        cyc("frz_br_after", O_RUN);
        ex_branch_taken = 1'b1; imem_busy = 1'b1;
        cyc("br_busy2", O_BR_BSY);
        clear_in(); dmem_busy = 1'b1;
        cyc("frz_pend", O_FRZ);
        dmem_busy = 1'b0;
        cyc("pend_clear2", O_PCLR);
        cyc("pend_done2", O_RUN);

        // reset during MD_WAIT with flush pending
        ex_branch_taken = 1'b1; imem_busy = 1'b1;
        cyc("br_busy3", O_BR_BSY);
        ex_branch_taken = 1'b0; ex_muldiv_start = 1'b1;
        cyc("md_pend_enter", O_MD);
        cyc("md_pend_wait", O_MD);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_in();
        exp_cnt = 0;
        check_vec("rst_cnt", 32'(stall_cycles), 32'd0);
        cyc("rst_run", O_RUN);
        cyc("rst_no_pend", O_RUN);
        check_vec("rst_cnt2", 32'(stall_cycles), exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
